wb_arbiter: RTL

- Shares the single register-file writeback/commit path between NUM_REQ execution-side requesters, e.g. 0=EXU/ALU, 1=LSU load return, 2=MDU/CSR.
- Each cycle, selects at most one valid requester by round-robin or fixed priority.
- Registers the winner's writeback bundle into a one-entry output slot that feeds the commit pipeline register.
- Keeps a retired-instruction counter.

---
 rtl/wb_arbiter_pkg.sv | 34 +++
 rtl/wb_arbiter_if.sv | 51 +++++
 rtl/wb_arbiter_rr_arbiter.sv | 47 ++++
 rtl/wb_arbiter.sv | 102 ++++++++++
 4 files changed

// File: rtl/wb_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// wb_arbiter_pkg : requester ids, writeback bundle type, index-width helper
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package wb_arbiter_pkg;

  localparam int REQ_EXU = 0;
  localparam int REQ_LSU = 1;
  localparam int REQ_MDU = 2;

  localparam int WB_DATA_W = 64;
  localparam int WB_ADDR_W = 5;
  localparam int WB_INST_W = 32;
  localparam int WB_PC_W   = 64;
  localparam int GID_W     = 3;
  localparam int CNT_W     = 64;

  typedef struct packed {
    logic                 wen;
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
    logic [WB_INST_W-1:0] inst;
    logic [WB_PC_W-1:0]   pc;
  } wb_bundle_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/wb_arbiter_if.sv
// ---------------------------------------------------------------------------
// wb_arbiter_if : requester bundles in, committed writeback slot out
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface wb_arbiter_if
  import wb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = WB_DATA_W,
  parameter int ADDR_W  = WB_ADDR_W,
  parameter int INST_W  = WB_INST_W,
  parameter int PC_W    = WB_PC_W
);

  logic [NUM_REQ-1:0]        req_valid_i;
  logic [NUM_REQ-1:0]        req_ready_o;
  logic [NUM_REQ-1:0]        req_wen_i;
  logic [NUM_REQ*ADDR_W-1:0] req_addr_i;
  logic [NUM_REQ*DATA_W-1:0] req_data_i;
  logic [NUM_REQ*INST_W-1:0] req_inst_i;
  logic [NUM_REQ*PC_W-1:0]   req_pc_i;
  logic                      flush_i;
  logic                      out_valid_o;
  logic                      out_ready_i;
  logic                      wb_en_o;
  logic [ADDR_W-1:0]         wb_addr_o;
  logic [DATA_W-1:0]         wb_data_o;
  logic [INST_W-1:0]         inst_o;
  logic [PC_W-1:0]           pc_o;
  logic [GID_W-1:0]          grant_id_o;
  logic [CNT_W-1:0]          commit_cnt_o;

  modport slave (
    input  req_valid_i, req_wen_i, req_addr_i, req_data_i, req_inst_i,
           req_pc_i, flush_i, out_ready_i,
    output req_ready_o, out_valid_o, wb_en_o, wb_addr_o, wb_data_o,
           inst_o, pc_o, grant_id_o, commit_cnt_o
  );

  modport master (
    output req_valid_i, req_wen_i, req_addr_i, req_data_i, req_inst_i,
           req_pc_i, flush_i, out_ready_i,
    input  req_ready_o, out_valid_o, wb_en_o, wb_addr_o, wb_data_o,
           inst_o, pc_o, grant_id_o, commit_cnt_o
  );

endinterface

`default_nettype wire

// File: rtl/wb_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter : combinational round-robin / fixed-priority one-hot arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int RR_EN   = 1,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_valid
);

  int w_base;

  // Two passes: indices at/after the pointer first, then the wrapped-around ones.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_base  = (RR_EN != 0) ? int'(i_ptr) : 0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!o_valid && i_req[j] && (j >= w_base)) begin
        o_valid    = 1'b1;
        o_grant[j] = 1'b1;
        o_idx      = IDX_W'(j);
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!o_valid && i_req[j] && (j < w_base)) begin
        o_valid    = 1'b1;
        o_grant[j] = 1'b1;
        o_idx      = IDX_W'(j);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/wb_arbiter.sv
// ---------------------------------------------------------------------------
// wb_arbiter : arbitrates NUM_REQ writeback requesters into one commit slot
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = WB_DATA_W,
  parameter int ADDR_W  = WB_ADDR_W,
  parameter int INST_W  = WB_INST_W,
  parameter int PC_W    = WB_PC_W,
  parameter int RR_EN   = 1
) (
  input  logic          clk,
  input  logic          rst,
  wb_arbiter_if.slave   bus
);

  localparam int IDX_W = idx_width(NUM_REQ);

  logic [NUM_REQ-1:0] w_grant;
  logic [IDX_W-1:0]   w_idx;
  logic               w_any;
  logic               w_load_en;
  logic               w_hs;
  logic               w_consume;
  int                 w_sel;
  wb_bundle_t         w_bundle;

  logic [IDX_W-1:0]   r_ptr;
  logic               r_out_valid;
  wb_bundle_t         r_slot;
  logic [GID_W-1:0]   r_gid;
  logic [CNT_W-1:0]   r_cnt;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .RR_EN   (RR_EN),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .i_req   (bus.req_valid_i),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_valid (w_any)
  );

  assign w_load_en       = (!r_out_valid || bus.out_ready_i) && !bus.flush_i;
  assign bus.req_ready_o = w_grant & {NUM_REQ{w_load_en}};
  assign w_hs            = w_any && w_load_en;
  assign w_consume       = r_out_valid && bus.out_ready_i;
  assign w_sel           = int'(w_idx);

  // Writes to x0 still commit, just without a regfile write.
  always_comb begin
    w_bundle.addr = bus.req_addr_i[w_sel*ADDR_W +: ADDR_W];
    w_bundle.data = bus.req_data_i[w_sel*DATA_W +: DATA_W];
    w_bundle.inst = bus.req_inst_i[w_sel*INST_W +: INST_W];
    w_bundle.pc   = bus.req_pc_i[w_sel*PC_W +: PC_W];
    w_bundle.wen  = bus.req_wen_i[w_idx] && (|w_bundle.addr);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr       <= '0;
      r_out_valid <= 1'b0;
      r_slot      <= '0;
      r_gid       <= '0;
      r_cnt       <= '0;
    end else begin
      if (w_consume) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_hs) begin
        r_slot      <= w_bundle;
        r_out_valid <= 1'b1;
        r_gid       <= GID_W'(w_idx);
        if (RR_EN != 0) begin
          r_ptr <= (w_idx == IDX_W'(NUM_REQ-1)) ? '0 : w_idx + IDX_W'(1);
        end
      end else if (w_consume || bus.flush_i) begin
        r_out_valid <= 1'b0;
        r_slot.wen  <= 1'b0;
      end
    end
  end

  assign bus.out_valid_o  = r_out_valid;
  assign bus.wb_en_o      = r_slot.wen;
  assign bus.wb_addr_o    = r_slot.addr;
  assign bus.wb_data_o    = r_slot.data;
  assign bus.inst_o       = r_slot.inst;
  assign bus.pc_o         = r_slot.pc;
  assign bus.grant_id_o   = r_gid;
  assign bus.commit_cnt_o = r_cnt;

endmodule

`default_nettype wire
